// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline stage feeding the writeback mux31.
//   Registers the EX/MEM result and drives mux31 operands a=ALU, b=load data, c=PC+4, plus select,
//   rd and write enable. A load parks the stage in LOAD_WAIT until the data-memory response
//   arrives; the returned word is aligned and sign/zero-extended by ld_funct3 and byte offset.
//   Optional feature macro: WB_TIMEOUT_EN adds a LOAD_WAIT watchdog (TIMEOUT_CYCLES) that
//   abandons the load, pulses wb_err and drops the late response.
// Ports:
//   clk, rst (sync, active high)
//   in_valid/in_ready         EX/MEM handshake; flush discards held/pending instruction
//   alu_res, pc4, rd, reg_we, wb_sel, is_load, ld_funct3   instruction fields
//   mem_rvalid, mem_rdata     data-memory load response
//   wb_a/b/c/s, wb_rd, wb_we  mux31 operands/select and regfile write
//   wb_valid                  retiring-instruction pulse; wb_err watchdog pulse
module wb_stage #(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [N-1:0] alu_res,
    input  logic [N-1:0] pc4,
    input  logic [4:0]   rd,
    input  logic         reg_we,
    input  logic [1:0]   wb_sel,
    input  logic         is_load,
    input  logic [2:0]   ld_funct3,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] wb_a,
    output logic [N-1:0] wb_b,
    output logic [N-1:0] wb_c,
    output logic [1:0]   wb_s,
    output logic [4:0]   wb_rd,
    output logic         wb_we,
    output logic         wb_valid,
    output logic         wb_err
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [0:0]   state;
    logic         drop;      // a late response is still owed by memory; swallow it
    logic [N-1:0] l_alu;
    logic [N-1:0] l_pc4;
    logic [4:0]   l_rd;
    logic         l_we;
    logic [2:0]   l_f3;
    logic [N-1:0] ld_data;

    assign in_ready = (state == IDLE) && !drop;

    // Load alignment using the latched byte offset.
    always_comb begin
        logic [1:0]  off;
        logic [7:0]  b8;
        logic [15:0] h16;
        off = l_alu[1:0];
        b8  = mem_rdata[{off, 3'b000} +: 8];
        h16 = mem_rdata[{off[1], 4'b0000} +: 16];
        ld_data = mem_rdata;
        case (l_f3)
            3'b000:  ld_data = {{(N-8){b8[7]}}, b8};
            3'b001:  ld_data = {{(N-16){h16[15]}}, h16};
            3'b100:  ld_data = {{(N-8){1'b0}}, b8};
            3'b101:  ld_data = {{(N-16){1'b0}}, h16};
            default: ld_data = mem_rdata;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
`else
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            drop     <= 1'b0;
            l_alu    <= '0;
            l_pc4    <= '0;
            l_rd     <= '0;
            l_we     <= 1'b0;
            l_f3     <= '0;
            wb_a     <= '0;
            wb_b     <= '0;
            wb_c     <= '0;
            wb_s     <= '0;
            wb_rd    <= '0;
            wb_we    <= 1'b0;
            wb_valid <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err   <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (drop) begin
                        if (mem_rvalid) drop <= 1'b0;
                    end else if (in_valid && !flush) begin
                        if (is_load) begin
                            l_alu <= alu_res;
                            l_pc4 <= pc4;
                            l_rd  <= rd;
                            l_we  <= reg_we;
                            l_f3  <= ld_funct3;
                            state <= LOAD_WAIT;
`ifdef WB_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            wb_a     <= alu_res;
                            wb_c     <= pc4;
                            wb_s     <= (wb_sel == 2'b11) ? 2'b10 : wb_sel;
                            wb_rd    <= rd;
                            wb_we    <= reg_we && (rd != 5'd0);
                            wb_valid <= 1'b1;
                        end
                    end
                end
                default: begin  // LOAD_WAIT
                    if (mem_rvalid) begin
                        state <= IDLE;
                        // A flush in the response cycle consumes the data without retiring.
                        if (!flush) begin
                            wb_a     <= l_alu;
                            wb_b     <= ld_data;
                            wb_c     <= l_pc4;
                            wb_s     <= 2'b01;
                            wb_rd    <= l_rd;
                            wb_we    <= l_we && (l_rd != 5'd0);
                            wb_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= IDLE;
                        drop  <= 1'b1;
`ifdef WB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
`ifdef WB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state  <= IDLE;
                        drop   <= 1'b1;
                        wb_err <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] alu_res, pc4, mem_rdata;
    logic [4:0]  rd;
    logic        reg_we, is_load, mem_rvalid;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_funct3;
    logic [31:0] wb_a, wb_b, wb_c;
    logic [1:0]  wb_s;
    logic [4:0]  wb_rd;
    logic        wb_we, wb_valid, wb_err;

    typedef struct {
        logic [1:0]  s;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.N(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .alu_res(alu_res), .pc4(pc4), .rd(rd), .reg_we(reg_we), .wb_sel(wb_sel),
        .is_load(is_load), .ld_funct3(ld_funct3), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_a(wb_a), .wb_b(wb_b), .wb_c(wb_c), .wb_s(wb_s),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_valid(wb_valid), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Scoreboard consumer: every retire must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (q.size() == 0) begin
                check("unexpected_retire", {31'd0, wb_valid}, 32'd0);
            end else begin
                exp_t e;
                logic [31:0] v;
                e = q.pop_front();
                v = (e.s == 2'b00) ? wb_a : (e.s == 2'b01) ? wb_b : wb_c;
                check("wb_s", {30'd0, wb_s}, {30'd0, e.s});
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                check("wb_val", v, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [31:0] pc, input logic [4:0] r,
                          input logic we, input logic [1:0] sel,
                          input logic [1:0] es, input logic [31:0] ev, input logic ewe);
        check("alu_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; is_load = 1'b0;
        alu_res = a; pc4 = pc; rd = r; reg_we = we; wb_sel = sel;
        q.push_back('{s: es, rd: r, we: ewe, val: ev});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                              input logic we);
        check("ld_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; is_load = 1'b1; ld_funct3 = f3;
        alu_res = a; pc4 = 32'h100; rd = r; reg_we = we; wb_sel = 2'b01;
        tick();
        in_valid = 1'b0; is_load = 1'b0;
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                           input logic we, input logic [31:0] data, input int waits,
                           input logic [31:0] ev);
        issue_load(f3, a, r, we);
        for (int i = 0; i < waits; i++) begin
            check("wait_in_ready", {31'd0, in_ready}, 32'd0);
            if (i == waits - 1) begin
                mem_rvalid = 1'b1; mem_rdata = data;
                q.push_back('{s: 2'b01, rd: r, we: we && (r != 5'd0), val: ev});
            end
            tick();
        end
        mem_rvalid = 1'b0;
        check("post_ld_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [4:0]  r;
        logic        we;
        logic [31:0] data;
        int          waits;
        logic [31:0] ev;
    } ld_t;

    ld_t lds[8];

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_res = '0; pc4 = '0; rd = '0;
        reg_we = 1'b0; wb_sel = '0; is_load = 1'b0; ld_funct3 = '0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_wb_a", wb_a, 32'd0);
        check("rst_wb_b", wb_b, 32'd0);
        check("rst_wb_c", wb_c, 32'd0);
        check("rst_wb_s", {30'd0, wb_s}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_flags", {29'd0, wb_we, wb_valid, wb_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ALU / JAL writebacks, select folding and rd=0 suppression.
        alu_op(32'h0000_1234, 32'h44, 5'd5, 1'b1, 2'b00, 2'b00, 32'h0000_1234, 1'b1);
        alu_op(32'h0000_0011, 32'h80, 5'd1, 1'b1, 2'b10, 2'b10, 32'h80, 1'b1);
        alu_op(32'h0000_0022, 32'h84, 5'd2, 1'b1, 2'b11, 2'b10, 32'h84, 1'b1);
        alu_op(32'hFFFF_0000, 32'h88, 5'd7, 1'b0, 2'b00, 2'b00, 32'hFFFF_0000, 1'b0);
        alu_op(32'h0000_0033, 32'h8C, 5'd0, 1'b1, 2'b00, 2'b00, 32'h33, 1'b0);

        lds[0] = '{3'b000, 32'h1001, 5'd3, 1'b1, 32'h0000_8000, 3, 32'hFFFF_FF80};
        lds[1] = '{3'b101, 32'h2002, 5'd4, 1'b1, 32'hBEEF_0000, 2, 32'h0000_BEEF};
        lds[2] = '{3'b010, 32'h3000, 5'd0, 1'b1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
        lds[3] = '{3'b001, 32'h4003, 5'd6, 1'b1, 32'h8001_0000, 2, 32'hFFFF_8001};
        lds[4] = '{3'b100, 32'h5003, 5'd8, 1'b1, 32'hA500_0000, 1, 32'h0000_00A5};
        lds[5] = '{3'b011, 32'h6000, 5'd9, 1'b1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        lds[6] = '{3'b001, 32'h7000, 5'd10, 1'b1, 32'h1234_7FFF, 2, 32'h0000_7FFF};
        lds[7] = '{3'b000, 32'h8002, 5'd11, 1'b0, 32'h007F_0000, 1, 32'h0000_007F};
        foreach (lds[i])
            load_op(lds[i].f3, lds[i].a, lds[i].r, lds[i].we, lds[i].data, lds[i].waits,
                    lds[i].ev);

        // An ALU retire must leave the load operand untouched.
        alu_op(32'h55, 32'h90, 5'd12, 1'b1, 2'b00, 2'b00, 32'h55, 1'b1);
        check("wb_b_hold", wb_b, 32'h0000_007F);

        // Flush in LOAD_WAIT, response two cycles later is dropped.
        issue_load(3'b010, 32'h100, 5'd13, 1'b1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("drop_ready0", {31'd0, in_ready}, 32'd0);
        tick();
        check("drop_ready1", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; tick(); mem_rvalid = 1'b0;
        check("drop_cleared", {31'd0, in_ready}, 32'd1);

        // Flush together with the response: consumed, no retire, no drop.
        issue_load(3'b010, 32'h104, 5'd14, 1'b1);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick(); flush = 1'b0; mem_rvalid = 1'b0;
        check("flush_rv_ready", {31'd0, in_ready}, 32'd1);

        // Flush in IDLE blocks the accept.
        in_valid = 1'b1; flush = 1'b1; alu_res = 32'h66; rd = 5'd15; reg_we = 1'b1;
        wb_sel = 2'b00; tick(); in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_valid", {31'd0, wb_valid}, 32'd0);

        // Stray response in IDLE ignored.
        mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
        check("stray_rv_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-load.
        issue_load(3'b010, 32'h108, 5'd16, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_wb_a", wb_a, 32'd0);
        mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
        alu_op(32'h77, 32'h94, 5'd17, 1'b1, 2'b00, 2'b00, 32'h77, 1'b1);

`ifdef WB_TIMEOUT_EN
        issue_load(3'b010, 32'h10C, 5'd18, 1'b1);
        tick(); tick(); tick();
        check("to_err_early", {31'd0, wb_err}, 32'd0);
        tick();
        check("to_err", {31'd0, wb_err}, 32'd1);
        check("to_we", {31'd0, wb_we}, 32'd0);
        check("to_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("to_err_pulse", {31'd0, wb_err}, 32'd0);
        mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
        check("to_drop_clear", {31'd0, in_ready}, 32'd1);
`else
        issue_load(3'b010, 32'h10C, 5'd18, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("long_wait_err", {31'd0, wb_err}, 32'd0);
            check("long_wait_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        q.push_back('{s: 2'b01, rd: 5'd18, we: 1'b1, val: 32'h3333_4444});
        tick(); mem_rvalid = 1'b0;
`endif

        tick(); tick();
        check("sb_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
